// File: rtl/hub75_pkg.sv
// -----------------------------------------------------------------------------
// hub75_pkg
//   Shared definitions for the HUB75 panel drivers.
//   - state_t      : plane shifter FSM encoding (IDLE is all-zero so a reset
//                    register reads as idle on the debug output)
//   - CH_*         : channel field indices inside a framebuffer word. Field 0
//                    (R0) is the most significant field of {R0,G0,B0,R1,G1,B1}.
//   - DEF_*        : default geometry for a 64-wide panel with 3-bit colour
//   - plane_width  : width of a plane counter for a given colour depth
// -----------------------------------------------------------------------------
package hub75_pkg;

    localparam int DEF_COLS       = 64;
    localparam int DEF_RESOLUTION = 3;

    // Number of colour channels per framebuffer word (two RGB pixels: the
    // upper and lower half of the panel are driven together).
    localparam int NUM_CH = 6;

    localparam int CH_R0 = 0;
    localparam int CH_G0 = 1;
    localparam int CH_B0 = 2;
    localparam int CH_R1 = 3;
    localparam int CH_G1 = 4;
    localparam int CH_B1 = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_WAIT   = 3'd2,
        S_DATA   = 3'd3,
        S_CLK_HI = 3'd4,
        S_CLK_LO = 3'd5,
        S_LATCH  = 3'd6,
        S_SHOW   = 3'd7
    } state_t;

    // A single-plane configuration still needs a 1-bit counter.
    function automatic int plane_width(input int resolution);
        return (resolution > 1) ? $clog2(resolution) : 1;
    endfunction

endpackage

// File: rtl/acumulador.sv
// -----------------------------------------------------------------------------
// acumulador
//   Free-running up counter with synchronous clear and count enable. The
//   asynchronous active-low reset lets an enclosing block abort mid-count.
//   Ports:
//     clk  - clock, posedge
//     rst  - asynchronous reset, active-low
//     clr  - synchronous clear to zero (has priority over en)
//     en   - increment by one
//     q    - counter value
// -----------------------------------------------------------------------------
module acumulador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/hub75_bit_select.sv
// -----------------------------------------------------------------------------
// hub75_bit_select
//   Combinational extraction of one bit plane from a framebuffer word.
//   The word holds six RESOLUTION-bit channel fields, R0 in the most
//   significant position: {R0,G0,B0,R1,G1,B1}. The output carries bit[plane]
//   of each field in the same order, ready to be shifted to the panel.
//   Ports:
//     word  - framebuffer word, NUM_CH*RESOLUTION bits
//     plane - bit plane to extract (must be < RESOLUTION)
//     bits  - {R0,G0,B0,R1,G1,B1} serial bits
// -----------------------------------------------------------------------------
module hub75_bit_select
    import hub75_pkg::*;
#(
    parameter int RESOLUTION = DEF_RESOLUTION,
    parameter int PLANE_W    = plane_width(DEF_RESOLUTION)
) (
    input  logic [NUM_CH*RESOLUTION-1:0] word,
    input  logic [PLANE_W-1:0]           plane,
    output logic [NUM_CH-1:0]            bits
);

    logic [RESOLUTION-1:0] field [NUM_CH];

    // Channel ch occupies field slot ch counted from the MSB end.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_field
        assign field[ch] = word[(NUM_CH-ch)*RESOLUTION-1 -: RESOLUTION];
    end

    assign bits = {field[CH_R0][plane], field[CH_G0][plane], field[CH_B0][plane],
                   field[CH_R1][plane], field[CH_G1][plane], field[CH_B1][plane]};

endmodule

// File: rtl/hub75_plane_shifter.sv
// -----------------------------------------------------------------------------
// hub75_plane_shifter
//   Drives one HUB75 row through bit-angle modulation. For every bit plane
//   (LSB first) the row is shifted out column by column, latched into the
//   panel, and display time is handed to the BCM timer. The timer answers
//   with NEXT_PLANE (shift the next plane) or FINISHED (row complete).
//
//   Ports:
//     clk, rst          - clock (posedge), asynchronous active-low reset
//     in_START, in_ROW  - start a row (accepted only when idle)
//     out_MEM_ADDR      - framebuffer address {row, col}
//     in_MEM_DATA       - framebuffer word, valid one cycle after the address
//     out_RGB           - {R0,G0,B0,R1,G1,B1} serial data to the panel
//     out_SCLK          - panel shift clock
//     out_LATCH         - panel latch strobe (one cycle)
//     out_OE_N          - panel output enable, active-low
//     out_ROW_ADDR      - panel A..E row select
//     out_BCM_INIT      - one-cycle pulse after latching plane 0
//     out_BCM_CONTINUE  - one-cycle pulse after latching planes 1..N
//     in_NEXT_PLANE     - timer: plane time elapsed
//     in_FINISHED       - timer: last plane elapsed (wins over NEXT_PLANE)
//     in_BRIGHT_DIM     - timer: blank the panel while showing
//     out_ROW_DONE      - one-cycle pulse once the row has finished
//     out_BUSY          - high whenever the FSM is not idle
//     out_DBG_STATE     - current FSM state (state_t encoding)
//
//   Handshake: in_START is a single-cycle request sampled on posedge while
//   idle; requests seen outside idle are dropped. The timer signals are plain
//   synchronous inputs sampled on posedge in SHOW; the BCM pulses are
//   registered and appear in the first SHOW cycle.
// -----------------------------------------------------------------------------
module hub75_plane_shifter
    import hub75_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int RESOLUTION = DEF_RESOLUTION,
    parameter int ROW_W      = 5,
    parameter int COL_W      = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_START,
    input  logic [ROW_W-1:0]           in_ROW,
    output logic [ROW_W+COL_W-1:0]     out_MEM_ADDR,
    input  logic [NUM_CH*RESOLUTION-1:0] in_MEM_DATA,
    output logic [NUM_CH-1:0]          out_RGB,
    output logic                       out_SCLK,
    output logic                       out_LATCH,
    output logic                       out_OE_N,
    output logic [ROW_W-1:0]           out_ROW_ADDR,
    output logic                       out_BCM_INIT,
    output logic                       out_BCM_CONTINUE,
    input  logic                       in_NEXT_PLANE,
    input  logic                       in_FINISHED,
    input  logic                       in_BRIGHT_DIM,
    output logic                       out_ROW_DONE,
    output logic                       out_BUSY,
    output logic [2:0]                 out_DBG_STATE
);

    localparam int PLANE_W = plane_width(RESOLUTION);

    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(RESOLUTION - 1);

    state_t state;
    state_t state_next;

    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col;
    logic [PLANE_W-1:0] plane;

    logic col_clr;
    logic col_inc;
    logic plane_clr;
    logic plane_inc;

    logic [NUM_CH-1:0] rgb_sel;
    logic [NUM_CH-1:0] rgb_q;
    logic              sclk_q;
    logic              latch_q;
    logic              init_q;
    logic              cont_q;
    logic              done_q;

    // -------------------------------------------------------------------------
    // Counters
    // -------------------------------------------------------------------------
    acumulador #(.W(COL_W)) u_col_cnt (
        .clk (clk),
        .rst (rst),
        .clr (col_clr),
        .en  (col_inc),
        .q   (col)
    );

    acumulador #(.W(PLANE_W)) u_plane_cnt (
        .clk (clk),
        .rst (rst),
        .clr (plane_clr),
        .en  (plane_inc),
        .q   (plane)
    );

    // -------------------------------------------------------------------------
    // Plane bit extraction from the framebuffer word
    // -------------------------------------------------------------------------
    hub75_bit_select #(
        .RESOLUTION (RESOLUTION),
        .PLANE_W    (PLANE_W)
    ) u_bit_select (
        .word  (in_MEM_DATA),
        .plane (plane),
        .bits  (rgb_sel)
    );

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and counter controls
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        col_clr    = 1'b0;
        col_inc    = 1'b0;
        plane_clr  = 1'b0;
        plane_inc  = 1'b0;

        case (state)
            S_IDLE: begin
                if (in_START) begin
                    state_next = S_ADDR;
                    col_clr    = 1'b1;
                    plane_clr  = 1'b1;
                end
            end
            S_ADDR:   state_next = S_WAIT;
            S_WAIT:   state_next = S_DATA;
            S_DATA:   state_next = S_CLK_HI;
            S_CLK_HI: state_next = S_CLK_LO;
            S_CLK_LO: begin
                if (col == LAST_COL) begin
                    state_next = S_LATCH;
                end else begin
                    col_inc    = 1'b1;
                    state_next = S_ADDR;
                end
            end
            S_LATCH:  state_next = S_SHOW;
            S_SHOW: begin
                if (in_FINISHED) begin
                    state_next = S_IDLE;
                end else if (in_NEXT_PLANE) begin
                    // At the last plane the counter holds and the same plane
                    // is shifted again.
                    state_next = S_ADDR;
                    col_clr    = 1'b1;
                    plane_inc  = (plane != LAST_PLANE);
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q   <= '0;
            rgb_q   <= '0;
            sclk_q  <= 1'b0;
            latch_q <= 1'b0;
            init_q  <= 1'b0;
            cont_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && in_START) begin
                row_q <= in_ROW;
            end
            // The read word is valid during WAIT; capturing it here puts the
            // new bits on the panel in DATA, a full cycle ahead of SCLK rising,
            // and holds them through CLK_HI/CLK_LO.
            if (state == S_WAIT) begin
                rgb_q <= rgb_sel;
            end
            // Strobes are decoded from the next state so they leave a flop
            // and stay glitch-free on the panel cable.
            sclk_q  <= (state_next == S_CLK_HI);
            latch_q <= (state_next == S_LATCH);
            init_q  <= (state == S_LATCH) && (plane == '0);
            cont_q  <= (state == S_LATCH) && (plane != '0);
            done_q  <= (state == S_SHOW) && in_FINISHED;
        end
    end

    // -------------------------------------------------------------------------
    // Output assignments
    // -------------------------------------------------------------------------
    assign out_MEM_ADDR     = {row_q, col};
    assign out_RGB          = rgb_q;
    assign out_SCLK         = sclk_q;
    assign out_LATCH        = latch_q;
    assign out_ROW_ADDR     = row_q;
    assign out_BCM_INIT     = init_q;
    assign out_BCM_CONTINUE = cont_q;
    assign out_ROW_DONE     = done_q;
    assign out_BUSY         = (state != S_IDLE);
    assign out_DBG_STATE    = state;

    // The panel is lit only while showing, and the timer may blank it
    // combinationally within the same cycle.
    assign out_OE_N = (state == S_SHOW) ? in_BRIGHT_DIM : 1'b1;

endmodule
